// File: rtl/fetch_pkg.sv
// Shared fetch-buffer sizing and the credit controller state encoding.
// The fetch FIFO wrapper and the credit controller both size themselves from here.
package fetch_pkg;

  localparam int unsigned FETCH_BUF_DEPTH    = 16;
  localparam int unsigned FETCH_LOG_DEPTH    = 4;
  localparam int unsigned FETCH_MAX_INFLIGHT = 2;
  localparam int unsigned FETCH_LOG_INFL     = 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_cred_state_e;

endpackage

// File: rtl/sat_updown_cnt.sv
// Up/down counter that saturates at 0 and MAX_VAL instead of wrapping.
// A load has priority over counting; an increment together with a decrement holds the count.
module sat_updown_cnt #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_clr_val,
  output logic [WIDTH-1:0] o_count,
  output logic             o_ovf,
  output logic             o_udf
);

  logic [WIDTH-1:0] r_count;
  logic             w_up;
  logic             w_dn;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_up      = i_inc & ~i_dec;
  assign w_dn      = i_dec & ~i_inc;
  assign w_at_max  = (r_count == WIDTH'(MAX_VAL));
  assign w_at_zero = (r_count == '0);

  // Flags report an attempted step past a bound; a load in the same cycle does not mask them.
  assign o_ovf = w_up & w_at_max;
  assign o_udf = w_dn & w_at_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= i_clr_val;
    end else if (w_up && !w_at_max) begin
      r_count <= r_count + WIDTH'(1);
    end else if (w_dn && !w_at_zero) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_credit_ctrl.sv
// Credit-based issue controller for the fetch FIFO: mirrors FIFO occupancy plus
// in-flight icache requests, and marks requests outstanding across a flush as stale.
module fetch_credit_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH        = FETCH_BUF_DEPTH,
  parameter int unsigned LOG_DEPTH    = FETCH_LOG_DEPTH,
  parameter int unsigned MAX_INFLIGHT = FETCH_MAX_INFLIGHT,
  parameter int unsigned LOG_INFL     = FETCH_LOG_INFL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                stall,
  input  logic                issue_req,
  output logic                issue_allow,
  output logic                issue_fire,
  input  logic                resp_valid,
  output logic                resp_drop,
  output logic                fifo_readygo,
  input  logic                fifo_pop_en,
  output logic [LOG_DEPTH:0]  occupancy,
  output logic [LOG_INFL:0]   inflight,
  output logic [LOG_INFL:0]   drop_cnt,
  output logic                draining,
  output logic                err
);

  localparam int unsigned OW = LOG_DEPTH + 1;
  localparam int unsigned IW = LOG_INFL + 1;

  fetch_cred_state_e r_state;
  logic              r_err;

  logic [OW-1:0] w_occ;
  logic [IW-1:0] w_infl;
  logic [IW-1:0] w_drop;
  logic [IW:0]   w_outstanding;
  logic [OW:0]   w_fill;
  logic [IW:0]   w_flush_rem;
  logic [IW-1:0] w_drop_load;
  logic          w_drop_nz;
  logic          w_accept;
  logic          w_stale;
  logic          w_occ_ovf, w_occ_udf;
  logic          w_infl_ovf, w_infl_udf;
  logic          w_drop_ovf, w_drop_udf;
  logic          w_err_evt;

  // Widened sums so the credit compares cannot overflow.
  assign w_outstanding = {1'b0, w_infl} + {1'b0, w_drop};
  assign w_fill        = {1'b0, w_occ} + (OW + 1)'(w_infl);
  assign w_drop_nz     = (w_drop != '0);

  assign issue_allow  = !rst && !flush && !stall
                     && (w_outstanding < (IW + 1)'(MAX_INFLIGHT))
                     && (w_fill < (OW + 1)'(DEPTH));
  assign issue_fire   = issue_req && issue_allow;
  assign resp_drop    = !rst && resp_valid && (flush || w_drop_nz);
  assign fifo_readygo = !rst && resp_valid && !resp_drop;

  assign w_accept = resp_valid && !w_drop_nz && !flush;
  assign w_stale  = resp_valid && w_drop_nz && !flush;

  // Everything outstanding turns stale on flush, except a response landing in that same cycle.
  always_comb begin
    w_flush_rem = '0;
    if (w_outstanding != '0) begin
      w_flush_rem = w_outstanding - (IW + 1)'(resp_valid);
    end
    w_drop_load = w_flush_rem[IW-1:0];
    if (w_flush_rem > (IW + 1)'(MAX_INFLIGHT)) begin
      w_drop_load = IW'(MAX_INFLIGHT);
    end
  end

  sat_updown_cnt #(.WIDTH(OW), .MAX_VAL(DEPTH)) u_occ_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_inc     (w_accept),
    .i_dec     (fifo_pop_en),
    .i_clr     (flush),
    .i_clr_val ('0),
    .o_count   (w_occ),
    .o_ovf     (w_occ_ovf),
    .o_udf     (w_occ_udf)
  );

  sat_updown_cnt #(.WIDTH(IW), .MAX_VAL(MAX_INFLIGHT)) u_infl_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_inc     (issue_fire),
    .i_dec     (w_accept),
    .i_clr     (flush),
    .i_clr_val ('0),
    .o_count   (w_infl),
    .o_ovf     (w_infl_ovf),
    .o_udf     (w_infl_udf)
  );

  sat_updown_cnt #(.WIDTH(IW), .MAX_VAL(MAX_INFLIGHT)) u_drop_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_inc     (1'b0),
    .i_dec     (w_stale),
    .i_clr     (flush),
    .i_clr_val (w_drop_load),
    .o_count   (w_drop),
    .o_ovf     (w_drop_ovf),
    .o_udf     (w_drop_udf)
  );

  assign w_err_evt = (resp_valid && (w_outstanding == '0))
                  || (fifo_pop_en && (w_occ == '0))
                  || w_occ_ovf || w_occ_udf
                  || w_infl_ovf || w_infl_udf
                  || w_drop_ovf || w_drop_udf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_err   <= 1'b0;
    end else begin
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ST_RUN: begin
          if (flush && (w_drop_load != '0)) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (flush) begin
            r_state <= (w_drop_load != '0) ? ST_DRAIN : ST_RUN;
          end else if (w_stale && (w_drop == IW'(1))) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign occupancy = w_occ;
  assign inflight  = w_infl;
  assign drop_cnt  = w_drop;
  assign draining  = (r_state == ST_DRAIN);
  assign err       = r_err;

endmodule

// File: tb/tb_fetch_credit_ctrl.sv
// Directed bench for fetch_credit_ctrl: credit limits, flush/stale draining and error flagging.
module tb_fetch_credit_ctrl;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       stall;
  logic       issue_req;
  logic       issue_allow;
  logic       issue_fire;
  logic       resp_valid;
  logic       resp_drop;
  logic       fifo_readygo;
  logic       fifo_pop_en;
  logic [4:0] occupancy;
  logic [1:0] inflight;
  logic [1:0] drop_cnt;
  logic       draining;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_credit_ctrl #(
    .DEPTH        (16),
    .LOG_DEPTH    (4),
    .MAX_INFLIGHT (2),
    .LOG_INFL     (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .stall        (stall),
    .issue_req    (issue_req),
    .issue_allow  (issue_allow),
    .issue_fire   (issue_fire),
    .resp_valid   (resp_valid),
    .resp_drop    (resp_drop),
    .fifo_readygo (fifo_readygo),
    .fifo_pop_en  (fifo_pop_en),
    .occupancy    (occupancy),
    .inflight     (inflight),
    .drop_cnt     (drop_cnt),
    .draining     (draining),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush       = 1'b0;
    stall       = 1'b0;
    issue_req   = 1'b0;
    resp_valid  = 1'b0;
    fifo_pop_en = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int accepted;
    logic prev_fire;

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    // Combinational outputs stay low while reset is held, whatever the inputs.
    issue_req  = 1'b1;
    resp_valid = 1'b1;
    #1;
    check("rst_allow",   issue_allow,  0);
    check("rst_drop",    resp_drop,    0);
    check("rst_readygo", fifo_readygo, 0);
    check("rst_drain",   draining,     0);
    check("rst_occ",     occupancy,    0);
    check("rst_infl",    inflight,     0);
    check("rst_dcnt",    drop_cnt,     0);
    check("rst_err",     err,          0);
    do_reset();

    // 1: fill the FIFO with back-to-back fire/response, no pops.
    accepted  = 0;
    prev_fire = 1'b0;
    for (int c = 0; c < 40; c++) begin
      issue_req  = 1'b1;
      resp_valid = prev_fire;
      #1;
      prev_fire = issue_fire;
      if (fifo_readygo) accepted++;
      tick();
    end
    idle_inputs();
    #1;
    check("fill_accepted", accepted,    16);
    check("fill_occ",      occupancy,   16);
    check("fill_allow",    issue_allow, 0);
    check("fill_err",      err,         0);
    do_reset();

    // 2: two outstanding requests exhaust the credit.
    issue_req = 1'b1;
    #1;
    check("cred_allow0", issue_allow, 1);
    tick();
    tick();
    check("cred_infl2",  inflight,    2);
    check("cred_block",  issue_allow, 0);
    issue_req  = 1'b0;
    resp_valid = 1'b1;
    #1;
    check("cred_readygo", fifo_readygo, 1);
    tick();
    resp_valid = 1'b0;
    #1;
    check("cred_reopen", issue_allow, 1);
    check("cred_infl1",  inflight,    1);
    check("cred_occ1",   occupancy,   1);

    // 3: flush with two outstanding and a non-empty FIFO.
    issue_req = 1'b1;
    tick();
    issue_req = 1'b0;
    flush     = 1'b1;
    #1;
    check("fl_allow_n", issue_allow, 0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_dcnt2",   drop_cnt,    2);
    check("fl_occ0",    occupancy,   0);
    check("fl_infl0",   inflight,    0);
    check("fl_drain",   draining,    1);
    check("fl_allow_b", issue_allow, 0);
    resp_valid = 1'b1;
    #1;
    check("fl_drop_a",    resp_drop,    1);
    check("fl_readygo_a", fifo_readygo, 0);
    tick();
    #1;
    check("fl_dcnt1",   drop_cnt,    1);
    check("fl_drain1",  draining,    1);
    check("fl_drop_b",  resp_drop,   1);
    check("fl_readygo_b", fifo_readygo, 0);
    tick();
    resp_valid = 1'b0;
    #1;
    check("fl_run",     draining,  0);
    check("fl_dcnt0",   drop_cnt,  0);
    check("fl_occ_end", occupancy, 0);
    check("fl_err",     err,       0);
    do_reset();

    // 4: flush and response in the same cycle.
    issue_req = 1'b1;
    tick();
    tick();
    issue_req  = 1'b0;
    flush      = 1'b1;
    resp_valid = 1'b1;
    #1;
    check("flr_drop",    resp_drop,    1);
    check("flr_readygo", fifo_readygo, 0);
    tick();
    flush      = 1'b0;
    resp_valid = 1'b0;
    #1;
    check("flr_dcnt1",  drop_cnt,    1);
    check("flr_drain",  draining,    1);
    check("flr_resume", issue_allow, 1);
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    #1;
    check("flr_run",    draining, 0);
    check("flr_err",    err,      0);
    do_reset();

    // 5: near-full FIFO with accepted write, pop and fire in one cycle.
    for (int k = 0; k < 14; k++) begin
      issue_req = 1'b1;
      tick();
      issue_req  = 1'b0;
      resp_valid = 1'b1;
      tick();
      resp_valid = 1'b0;
    end
    #1;
    check("mix_occ14", occupancy, 14);
    issue_req = 1'b1;
    tick();
    issue_req   = 1'b1;
    resp_valid  = 1'b1;
    fifo_pop_en = 1'b1;
    #1;
    check("mix_allow",   issue_allow,  1);
    check("mix_readygo", fifo_readygo, 1);
    tick();
    idle_inputs();
    #1;
    check("mix_occ",  occupancy, 14);
    check("mix_infl", inflight,  1);
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    #1;
    check("mix_occ15", occupancy, 15);
    check("mix_infl0", inflight,  0);
    check("mix_allow15", issue_allow, 1);
    issue_req   = 1'b1;
    fifo_pop_en = 1'b1;
    tick();
    idle_inputs();
    #1;
    check("pf_occ",  occupancy, 14);
    check("pf_infl", inflight,  1);
    check("mix_err", err,       0);
    do_reset();

    // 6: protocol errors are sticky until reset.
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    #1;
    check("err_resp", err, 1);
    tick();
    tick();
    tick();
    check("err_hold", err, 1);
    do_reset();
    #1;
    check("err_clr1", err, 0);
    fifo_pop_en = 1'b1;
    tick();
    fifo_pop_en = 1'b0;
    #1;
    check("err_pop",  err, 1);
    do_reset();
    #1;
    check("err_clr2", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
